// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal (BCD) arithmetic datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam bcd_digit_t BCD_RADIX = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = a - b - bin with decimal borrow correction.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout,
    output logic       nonbcd
);

    logic [4:0] t;

    // 5-bit two's complement difference; bit 4 is the sign for every 4-bit operand pair.
    assign t      = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    assign bout   = t[4];
    assign d      = bout ? (t[3:0] + BCD_RADIX) : t[3:0];
    assign nonbcd = (a > BCD_MAX) || (b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: diff = a - b - borrowIn, one digit per clock, LSD first,
// with a start/busy/done handshake and a sticky non-BCD input flag.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   borrowIn,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   borrowOut,
    output logic                   invalid
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NDIGITS - 1);

    state_t                   state;
    logic [IDXW-1:0]          idx;
    logic                     brw;
    bcd_digit_t [NDIGITS-1:0] a_q;
    bcd_digit_t [NDIGITS-1:0] b_q;
    bcd_digit_t [NDIGITS-1:0] diff_q;

    bcd_digit_t dig_d;
    logic       dig_bout;
    logic       dig_nonbcd;
    logic       accept;

    // start is only honoured outside RUN, so a held start cannot re-latch mid-operation.
    assign accept = start && (state != RUN);
    assign diff   = diff_q;

    bcd_digit_sub u_digit (
        .a      (a_q[idx]),
        .b      (b_q[idx]),
        .bin    (brw),
        .d      (dig_d),
        .bout   (dig_bout),
        .nonbcd (dig_nonbcd)
    );

    // NOTE: operand copies are pure datapath and are always loaded before use,
    // so they carry no reset; only control and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            brw       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff_q    <= '0;
            borrowOut <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        idx       <= '0;
                        brw       <= borrowIn;
                        diff_q    <= '0;
                        borrowOut <= 1'b0;
                        invalid   <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    diff_q[idx] <= dig_d;
                    brw         <= dig_bout;
                    invalid     <= invalid | dig_nonbcd;
                    if (idx == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        borrowOut <= dig_bout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub (NDIGITS=4): directed table, corner sequences,
// and random back-to-back operations against a decimal integer model.
module tb_bcd_serial_sub;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrowIn;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrowOut;
    logic         invalid;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         inv;
    } vec_t;

    vec_t tbl[8];

    bcd_serial_sub #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrowIn  (borrowIn),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrowOut (borrowOut),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] x);
        int v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Called at a negedge; start is seen at the next posedge, then operand inputs are scrambled.
    task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a = av; b = bv; borrowIn = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrowIn = 1'($urandom);
    endtask

    // Starts at the negedge after the accepting edge; returns cycles until done is seen.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb, input logic ei);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(borrowOut), 32'(eb));
        check({tag, "_inv"}, 32'(invalid), 32'(ei));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cyc, bcnt;
        apply(v.a, v.b, v.bin);
        wait_done(cyc, bcnt);
        check({tag, "_latency"}, 32'(cyc), 32'(ND));
        check({tag, "_busycnt"}, 32'(bcnt), 32'(ND));
        check_result(tag, v.d, v.bout, v.inv);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(diff), 32'(v.d));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, bcnt, seen;
        logic [W-1:0] ra, rb, na, nb;
        logic         rbi, nbi;
        int           m;

        tbl[0] = '{16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0};
        tbl[2] = '{16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{16'h12C4, 16'h0000, 1'b0, 16'h12C4, 1'b0, 1'b1};
        tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
        tbl[6] = '{16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h9999, 1'b0, 16'h0001, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; borrowIn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(borrowOut), 32'd0);
        check("rst_inv", 32'(invalid), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // start held high through RUN with changing operands: must not re-latch or restart.
        a = 16'h5000; b = 16'h4999; borrowIn = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 16'h9999; b = 16'h0000; borrowIn = 1'b0;
        wait_done(cyc, bcnt);
        start = 1'b0;
        check("hold_latency", 32'(cyc), 32'(ND));
        check("hold_busycnt", 32'(bcnt), 32'(ND));
        check_result("hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_idle", 32'(busy), 32'd0);

        // Reset in the middle of an operation aborts it without a done pulse.
        apply(16'h9999, 16'h0001, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(borrowOut), 32'd0);
        check("abort_inv", 32'(invalid), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_nodone", 32'(seen), 32'd0);
        run_vec("after_abort", tbl[0]);

        // Random valid operands, each new start issued in the DONE cycle of the previous one.
        ra = rand_bcd(); rb = rand_bcd(); rbi = 1'($urandom);
        apply(ra, rb, rbi);
        for (int k = 0; k < 40; k++) begin
            wait_done(cyc, bcnt);
            check($sformatf("rnd%0d_latency", k), 32'(cyc), 32'(ND));
            m = bcd_val(ra) - bcd_val(rb) - int'(rbi);
            check_result($sformatf("rnd%0d", k), to_bcd((m + 10000) % 10000),
                         (bcd_val(ra) < bcd_val(rb) + int'(rbi)), 1'b0);
            if (k < 39) begin
                na = rand_bcd(); nb = rand_bcd(); nbi = 1'($urandom);
                ra = na; rb = nb; rbi = nbi;
                apply(ra, rb, rbi);
                check($sformatf("rnd%0d_b2b_busy", k), 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
